pulse_scheduler: RTL
====================

// Module: pulse_scheduler
// PURPOSE
//   Shares one widened output-pulse channel among N_REQ event sources (e.g. heart-node activations).
//   Latches rising edges from each source, grants the channel round-robin, and emits fixed-width
//   pulses separated by a minimum low gap. Reports the owner of each pulse.
//   Sits between event generators and the board output pins; runs on the slow model clock (~1.5 kHz).
// PARAMETERS
//   N_REQ  4   number of requesters (2..16)
//   IDX_W  2   width of owner index; 2**IDX_W >= N_REQ
//   WIDTH  15  pulse high time in clk cycles (>=1); 15 cycles = 10 ms at 1.5 kHz
//   GAP    3   minimum low cycles between consecutive pulses (>=0)
//   CNT_W  16  counter width; WIDTH and GAP must each fit in CNT_W bits
// PORTS
//   clk        in   1      model clock, all logic on posedge
//   rst_n      in   1      synchronous active-low reset
//   req_i      in   N_REQ  per-source event level; only rising edges are significant
//   mask_i     in   N_REQ  1 = source disabled; its edges are ignored and never latched
//   pulse_o    out  1      shared widened pulse, registered
//   owner_o    out  IDX_W  index of the source being serviced; valid while pulse_o=1, else 0
//   busy_o     out  1      1 in PULSE or GAP state
//   pending_o  out  N_REQ  latched, not-yet-serviced requests
//   drop_o     out  1      1-cycle strobe: edge arrived on a source already pending (event lost)
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE, cnt=0, pending=0, pulse_o=0, owner_o=0, busy_o=0,
//     drop_o=0, last_grant=N_REQ-1 (source 0 has first priority), req_q<=req_i (levels held
//     across reset do not fire). Reset mid-pulse truncates the pulse; queued requests are discarded.
//   Edge detect: rise = req_i & ~req_q & ~mask_i; req_q<=req_i every cycle.
//   Pending: bit k set on rise[k]; cleared when k is granted; set wins if both happen in one cycle.
//     rise[k] while pending[k]=1 -> drop_o=1 next cycle, pending unchanged. Masking a source does
//     not clear an already-pending bit.
//   FSM states IDLE, PULSE, GAP:
//     IDLE : if pending!=0, grant first set bit searching last_grant+1, +2, ... (wrap at N_REQ);
//            owner<=grant, last_grant<=grant, cnt<=0, ->PULSE. Else stay.
//     PULSE: pulse_o=1; cnt++; when cnt==WIDTH-1: cnt<=0, ->GAP (or ->IDLE if GAP==0).
//     GAP  : pulse_o=0; cnt++; when cnt==GAP-1: cnt<=0, ->IDLE.
//   pulse_o, owner_o, busy_o are registered decodes of the next state: pulse_o high for exactly
//     WIDTH cycles per grant.
//   Latency: req_i rise sampled at edge t -> pending set after t -> pulse_o high after edge t+1
//     (2 cycles), when idle with nothing queued.
//   Back-to-back: low time between pulses = GAP+1 cycles (GAP cycles plus one IDLE arbitration
//     cycle).
//   Rise on the current owner during its pulse is queued and serviced by round-robin order later.
//   Simultaneous rises on several sources: all latched in one cycle; serviced in round-robin order.
//   Counter never wraps: it resets at the terminal value of each state.
// TESTING
//   Single: req_i[0] 0->1 at cycle 10 -> pulse_o high cycles 12..26 (15 cycles), owner_o=0,
//     busy_o through cycle 29.
//   Round-robin: req_i=4'b1111 rise together -> owners 0,1,2,3 in order; each pulse 15 high,
//     4 low between.
//   Drop/mask: two rises on src 2 before service -> one pulse, drop_o=1 once; rise on masked
//     src 1 -> no pulse, pending_o[1]=0.
//   Requeue: src 3 rises again mid-pulse of src 3 while src 0 pending -> order 3,0,3.
//   Reset mid-PULSE at cnt=7 with 2 pending -> next cycle pulse_o=0, pending_o=0, state IDLE;
//     a level held through reset does not fire.
//   GAP=0, WIDTH=1 build: 2 queued reqs -> pulse_o 1,0,1 on consecutive cycles.

Source files
------------

// File: rtl/pulse_scheduler.sv
// Round-robin scheduler that shares one widened output pulse among N_REQ edge-triggered sources.
// Each grant produces a WIDTH-cycle pulse followed by at least GAP low cycles.
module pulse_scheduler #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2,
    parameter int WIDTH = 15,
    parameter int GAP   = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] mask_i,
    output logic             pulse_o,
    output logic [IDX_W-1:0] owner_o,
    output logic             busy_o,
    output logic [N_REQ-1:0] pending_o,
    output logic             drop_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [CNT_W-1:0] WIDTH_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(N_REQ - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] pending_next;
    logic [N_REQ-1:0] rise;
    logic [N_REQ-1:0] grant_oh;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] last_grant_next;
    logic [IDX_W-1:0] owner_sel;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand_idx;
    logic             grant_found;

    assign rise         = req_i & ~req_q & ~mask_i;
    assign pending_next = (pending & ~grant_oh) | rise;
    assign pending_o    = pending;

    // Search starts just after the previous grant so every source gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand_idx = IDX_W'((int'(last_grant) + i) % N_REQ);
            if (!grant_found && pending[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        last_grant_next = last_grant;
        owner_sel       = owner_o;
        grant_oh        = '0;
        case (state)
            ST_IDLE: begin
                if (grant_found) begin
                    state_next      = ST_PULSE;
                    cnt_next        = '0;
                    owner_sel       = grant_idx;
                    last_grant_next = grant_idx;
                    grant_oh        = N_REQ'(1) << grant_idx;
                end
            end
            ST_PULSE: begin
                if (cnt == WIDTH_LAST) begin
                    cnt_next   = '0;
                    state_next = (GAP == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            pending    <= '0;
            last_grant <= LAST_INIT;
            req_q      <= req_i;
            pulse_o    <= 1'b0;
            owner_o    <= '0;
            busy_o     <= 1'b0;
            drop_o     <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            pending    <= pending_next;
            last_grant <= last_grant_next;
            req_q      <= req_i;
            pulse_o    <= (state_next == ST_PULSE);
            owner_o    <= (state_next == ST_PULSE) ? owner_sel : '0;
            busy_o     <= (state_next != ST_IDLE);
            drop_o     <= |(rise & pending);
        end
    end

endmodule
